fetch_pc_gen: RTL and testbench

FETCH_PC_GEN -- requirements
Module: fetch_pc_gen

---
 rtl/fetch_pc_gen_pkg.sv | 20 ++
 rtl/fetch_pc_gen_kogge_stone.sv | 45 ++++
 rtl/fetch_pc_gen.sv | 154 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator: FSM state encoding,
// fetch geometry constants and an alignment helper.
package fetch_pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // A fetch group is two 4-byte instruction slots.
    localparam logic [31:0] FETCH_GROUP_BYTES = 32'd8;
    localparam logic [31:0] INSTR_BYTES       = 32'd4;

    // A fetch target is legal only when it sits on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_pc_gen_kogge_stone.sv
// Parallel-prefix (Kogge-Stone) adder/subtractor. With sub_en_i=1 it
// returns in0_i - in1_i; otherwise in0_i + in1_i, both modulo 2^W.
module fetch_pc_gen_kogge_stone #(
    parameter int W = 32
) (
    input  logic [W-1:0] in0_i,
    input  logic [W-1:0] in1_i,
    input  logic         sub_en_i,
    output logic [W-1:0] sum_o
);

    // Only carries into bits 1..W-1 are needed, so the prefix tree spans W-1 bits.
    localparam int WC  = W - 1;
    localparam int LVL = $clog2(WC);

    logic [W-1:0]  b_s;
    logic [W-1:0]  p_all_s;
    logic [WC-1:0] g_s [0:LVL];
    logic [WC-1:0] p_s [0:LVL];
    logic [W-1:0]  c_s;

    // Operand conditioning, prefix tree of generate/propagate pairs, final sum.
    always_comb begin
        b_s     = in1_i ^ {W{sub_en_i}};
        p_all_s = in0_i ^ b_s;
        g_s[0]  = in0_i[WC-1:0] & b_s[WC-1:0];
        p_s[0]  = p_all_s[WC-1:0];
        // Fold the carry-in into bit 0 so every group generate includes it.
        g_s[0][0] = g_s[0][0] | (p_all_s[0] & sub_en_i);
        for (int k = 0; k < LVL; k++) begin
            for (int i = 0; i < WC; i++) begin
                if (i >= (1 << k)) begin
                    g_s[k+1][i] = g_s[k][i] | (p_s[k][i] & g_s[k][i - (1 << k)]);
                    p_s[k+1][i] = p_s[k][i] & p_s[k][i - (1 << k)];
                end else begin
                    g_s[k+1][i] = g_s[k][i];
                    p_s[k+1][i] = p_s[k][i];
                end
            end
        end
        c_s   = {g_s[LVL], sub_en_i};
        sum_o = p_all_s ^ c_s;
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: sequences the instruction-fetch address through
// 8-byte groups, applies branch/jump redirects with one cycle of latency,
// traps misaligned redirect targets into HALT and reports them.
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        fetch_slot1_valid,
    output logic [31:0] fetch_pc_plus4,
    output logic        exc_misalign,
    output logic [31:0] exc_addr
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        exc_q, exc_d;
    logic [31:0] exc_addr_q, exc_addr_d;

    logic [31:0] seq_step_s;
    logic [31:0] pc_seq_s;
    logic [31:0] pc_plus4_s;
    logic        fetch_valid_s;
    logic        handshake_s;
    logic        redirect_ok_s;
    logic        redirect_bad_s;

    // Step to the next group boundary: +4 from the upper slot, +8 from the lower.
    always_comb begin
        if (pc_q[2]) begin
            seq_step_s = INSTR_BYTES;
        end else begin
            seq_step_s = FETCH_GROUP_BYTES;
        end
    end

    fetch_pc_gen_kogge_stone #(.W(32)) u_seq_add (
        .in0_i    (pc_q),
        .in1_i    (seq_step_s),
        .sub_en_i (1'b0),
        .sum_o    (pc_seq_s)
    );

    fetch_pc_gen_kogge_stone #(.W(32)) u_plus4_add (
        .in0_i    (pc_q),
        .in1_i    (INSTR_BYTES),
        .sub_en_i (1'b0),
        .sum_o    (pc_plus4_s)
    );

    // State, PC and exception registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            exc_q      <= 1'b0;
            exc_addr_q <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            exc_q      <= exc_d;
            exc_addr_q <= exc_addr_d;
        end
    end

    // Next-state logic: redirects beat sequential advance; bad targets trap to HALT.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        exc_d          = 1'b0;
        exc_addr_d     = exc_addr_q;
        handshake_s    = fetch_valid_s & fetch_ready;
        redirect_ok_s  = redirect_valid & is_word_aligned(redirect_target);
        redirect_bad_s = redirect_valid & ~is_word_aligned(redirect_target);

        if (redirect_bad_s) begin
            exc_d      = 1'b1;
            exc_addr_d = redirect_target;
        end else begin
            exc_d      = 1'b0;
            exc_addr_d = exc_addr_q;
        end

        case (state_q)
            BOOT: begin
                if (redirect_bad_s) begin
                    state_d = HALT;
                end else if (redirect_ok_s) begin
                    pc_d    = redirect_target;
                    state_d = RUN;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect_bad_s) begin
                    state_d = HALT;
                end else begin
                    if (redirect_ok_s) begin
                        pc_d = redirect_target;
                    end else if (handshake_s) begin
                        pc_d = pc_seq_s;
                    end else begin
                        pc_d = pc_q;
                    end
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                if (redirect_ok_s) begin
                    pc_d = redirect_target;
                    if (halt_req) begin
                        state_d = HALT;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = HALT;
                end
            end
            default: begin
                state_d = BOOT;
                pc_d    = pc_q;
            end
        endcase
    end

    // Output decode: requests are presented only in RUN.
    always_comb begin
        case (state_q)
            RUN:     fetch_valid_s = 1'b1;
            default: fetch_valid_s = 1'b0;
        endcase
        fetch_valid       = fetch_valid_s;
        fetch_pc          = pc_q;
        fetch_slot1_valid = ~pc_q[2] & fetch_valid_s;
        fetch_pc_plus4    = pc_plus4_s;
        exc_misalign      = exc_q;
        exc_addr          = exc_addr_q;
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        fetch_slot1_valid;
    logic [31:0] fetch_pc_plus4;
    logic        exc_misalign;
    logic [31:0] exc_addr;

    int total = 0;
    int bad   = 0;
    logic [34:0] obs, exp;

    fetch_pc_gen #(.RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .halt_req          (halt_req),
        .fetch_ready       (fetch_ready),
        .fetch_valid       (fetch_valid),
        .fetch_pc          (fetch_pc),
        .fetch_slot1_valid (fetch_slot1_valid),
        .fetch_pc_plus4    (fetch_pc_plus4),
        .exc_misalign      (exc_misalign),
        .exc_addr          (exc_addr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redir(input logic [31:0] t);
        redirect_valid  = 1'b1;
        redirect_target = t;
    endtask

    task automatic no_redir();
        redirect_valid  = 1'b0;
        redirect_target = 32'h0000_0000;
    endtask

    // obs/exp layout: {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc}
    task automatic test_reset();
        rst_n = 1'b0; fetch_ready = 1'b1; halt_req = 1'b0; no_redir();
        step(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b0, 1'b0, 32'h0000_0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_state got=%h want=%h", obs, exp); end
        total++; if (fetch_pc_plus4 !== 32'h0000_0004) begin bad++; $display("FAIL reset_plus4 got=%h want=%h", fetch_pc_plus4, 32'h4); end
        total++; if (exc_addr !== 32'h0000_0000) begin bad++; $display("FAIL reset_exc_addr got=%h want=%h", exc_addr, 32'h0); end
    endtask

    task automatic test_boot_seq();
        rst_n = 1'b1;
        #1;
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b0, 1'b0, 32'h0000_0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL boot_cycle got=%h want=%h", obs, exp); end
        step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL run_pc0 got=%h want=%h", obs, exp); end
        for (int i = 1; i <= 3; i++) begin
            step();
            obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
            exp = {1'b0, 1'b1, 1'b1, 32'(i * 8)};
            total++; if (obs !== exp) begin bad++; $display("FAIL seq_pc%0d got=%h want=%h", i * 8, obs, exp); end
        end
    endtask

    task automatic test_redirect();
        redir(32'h0000_0104); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b0, 32'h0000_0104};
        total++; if (obs !== exp) begin bad++; $display("FAIL redir_104 got=%h want=%h", obs, exp); end
        total++; if (fetch_pc_plus4 !== 32'h0000_0108) begin bad++; $display("FAIL plus4_104 got=%h want=%h", fetch_pc_plus4, 32'h108); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0108};
        total++; if (obs !== exp) begin bad++; $display("FAIL after_104 got=%h want=%h", obs, exp); end
    endtask

    task automatic test_stall();
        redir(32'h0000_0040); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0040};
        total++; if (obs !== exp) begin bad++; $display("FAIL redir_40 got=%h want=%h", obs, exp); end
        no_redir(); fetch_ready = 1'b0; step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        total++; if (obs !== exp) begin bad++; $display("FAIL stall_hold got=%h want=%h", obs, exp); end
        redir(32'h0000_0200); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0200};
        total++; if (obs !== exp) begin bad++; $display("FAIL stall_redir got=%h want=%h", obs, exp); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        total++; if (obs !== exp) begin bad++; $display("FAIL stall_hold2 got=%h want=%h", obs, exp); end
        fetch_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        redir(32'h0000_0080); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0080};
        total++; if (obs !== exp) begin bad++; $display("FAIL hs_redir got=%h want=%h", obs, exp); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0088};
        total++; if (obs !== exp) begin bad++; $display("FAIL seq_88 got=%h want=%h", obs, exp); end
        total++; if (fetch_pc_plus4 !== 32'h0000_008C) begin bad++; $display("FAIL plus4_88 got=%h want=%h", fetch_pc_plus4, 32'h8C); end
    endtask

    task automatic test_misalign();
        redir(32'h0000_0102); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b1, 1'b0, 1'b0, 32'h0000_0088};
        total++; if (obs !== exp) begin bad++; $display("FAIL misalign_pulse got=%h want=%h", obs, exp); end
        total++; if (exc_addr !== 32'h0000_0102) begin bad++; $display("FAIL misalign_addr got=%h want=%h", exc_addr, 32'h102); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b0, 1'b0, 32'h0000_0088};
        total++; if (obs !== exp) begin bad++; $display("FAIL misalign_end got=%h want=%h", obs, exp); end
        total++; if (exc_addr !== 32'h0000_0102) begin bad++; $display("FAIL addr_held got=%h want=%h", exc_addr, 32'h102); end
        redir(32'h0000_0300); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0300};
        total++; if (obs !== exp) begin bad++; $display("FAIL halt_exit_300 got=%h want=%h", obs, exp); end
        no_redir();
    endtask

    task automatic test_halt();
        halt_req = 1'b1; step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b0, 1'b0, 32'h0000_0308};
        total++; if (obs !== exp) begin bad++; $display("FAIL halt_enter got=%h want=%h", obs, exp); end
        step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        total++; if (obs !== exp) begin bad++; $display("FAIL halt_hold got=%h want=%h", obs, exp); end
        redir(32'h0000_0400); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b0, 1'b0, 32'h0000_0400};
        total++; if (obs !== exp) begin bad++; $display("FAIL halt_load got=%h want=%h", obs, exp); end
        no_redir(); halt_req = 1'b0; step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        total++; if (obs !== exp) begin bad++; $display("FAIL halt_no_exit got=%h want=%h", obs, exp); end
        redir(32'h0000_0500); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0500};
        total++; if (obs !== exp) begin bad++; $display("FAIL halt_exit_500 got=%h want=%h", obs, exp); end
        no_redir();
    endtask

    task automatic test_wrap();
        redir(32'hFFFF_FFF8); step();
        total++; if (fetch_pc_plus4 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL plus4_fff8 got=%h want=%h", fetch_pc_plus4, 32'hFFFF_FFFC); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap8 got=%h want=%h", obs, exp); end
        redir(32'hFFFF_FFFC); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC};
        total++; if (obs !== exp) begin bad++; $display("FAIL pc_fffc got=%h want=%h", obs, exp); end
        total++; if (fetch_pc_plus4 !== 32'h0000_0000) begin bad++; $display("FAIL plus4_wrap got=%h want=%h", fetch_pc_plus4, 32'h0); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL wrap4 got=%h want=%h", obs, exp); end
    endtask

    task automatic test_reset_stall();
        redir(32'h0000_0700); step();
        no_redir(); fetch_ready = 1'b0; step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0700};
        total++; if (obs !== exp) begin bad++; $display("FAIL pre_reset_stall got=%h want=%h", obs, exp); end
        rst_n = 1'b0; step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b0, 1'b0, 32'h0000_0000};
        total++; if (obs !== exp) begin bad++; $display("FAIL reset_mid_req got=%h want=%h", obs, exp); end
        total++; if (exc_addr !== 32'h0000_0000) begin bad++; $display("FAIL reset_clears_addr got=%h want=%h", exc_addr, 32'h0); end
    endtask

    task automatic test_boot_redirect();
        rst_n = 1'b1; fetch_ready = 1'b1; redir(32'h0000_0600); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0600};
        total++; if (obs !== exp) begin bad++; $display("FAIL boot_redir got=%h want=%h", obs, exp); end
        no_redir(); step();
        obs = {exc_misalign, fetch_valid, fetch_slot1_valid, fetch_pc};
        exp = {1'b0, 1'b1, 1'b1, 32'h0000_0608};
        total++; if (obs !== exp) begin bad++; $display("FAIL boot_redir_seq got=%h want=%h", obs, exp); end
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0000_0000;
        halt_req = 1'b0; fetch_ready = 1'b1;
        test_reset();
        test_boot_seq();
        test_redirect();
        test_stall();
        test_back_to_back();
        test_misalign();
        test_halt();
        test_wrap();
        test_reset_stall();
        test_boot_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
